seg_hex_display_ctrl: RTL and testbench
=======================================

# seg_hex_display_ctrl

Eight-digit seven-segment display controller for the DE2i-150 HEX bank. It shares the display between two requesters that each write a 32-bit value over a valid/ready handshake, with round-robin arbitration on ties. It enforces a minimum on-screen hold time per accepted value. It applies per-digit blanking and blinking, then decodes each nibble to active-low segment patterns that drive the HEX0..HEX7 pins directly.

## Interface

Parameters:
- HOLD_CYC, default 25_000_000: minimum number of cycles an accepted value stays on screen before another write is accepted. 0 disables the hold.
- BLINK_DIV, default 12_500_000: blink half-period in cycles. Must be ≥1.

Ports:
- iCLK  in  1  system clock. All logic is on the rising edge.
- iRST_N  in  1  reset. Asynchronous assert, active-low.
- iREQ0_VALID  in  1  requester 0 has a value.
- iREQ0_DATA  in  32  requester 0 value. Nibble n goes to digit n (HEXn).
- oREQ0_READY  out  1  requester 0 transfer accepted this cycle.
- iREQ1_VALID  in  1  requester 1 has a value.
- iREQ1_DATA  in  32  requester 1 value.
- oREQ1_READY  out  1  requester 1 transfer accepted this cycle.
- iCFG_WE  in  1  configuration write strobe.
- iCFG_BLANK  in  8  bit n=1 blanks digit n permanently.
- iCFG_BLINK  in  8  bit n=1 makes digit n blink.
- oHEX0_D..oHEX7_D  out  7 each  segment outputs, active-low. Bit 0=a … bit 6=g.
- oOWNER  out  1  requester whose value is currently displayed.
- oUPDATE  out  1  one-cycle pulse when a new value is latched.

## Operation

- Reset (iRST_N low, asynchronous) does all of the following:
  - value register = 0, blank = 0, blink = 0.
  - state = IDLE, hold counter = 0.
  - blink counter = 0, blink phase = 0.
  - round-robin pointer last = 1, so requester 0 wins the first tie.
  - oOWNER = 0, oUPDATE = 0.
  - every oHEXn_D = 7'h40 (shows "0").
  - oREQ0_READY and oREQ1_READY are forced 0 while reset is low.
- State machine has two states: IDLE and HOLD.
  - IDLE: oREQ0_READY = VALID0 & (!VALID1 | last==1). oREQ1_READY = VALID1 & (!VALID0 | last==0). Both are combinational from the valids. At most one ready is high at a time.
  - A transfer occurs on a cycle with VALIDn & READYn. At that edge the controller:
    - latches DATAn into the value register;
    - sets oOWNER = n and last = n;
    - asserts oUPDATE for the following cycle;
    - if HOLD_CYC > 0, loads the hold counter with HOLD_CYC-1 and moves to HOLD; otherwise it stays in IDLE.
  - HOLD: both readies are 0. The counter decrements each cycle. When the counter is 0, the next edge returns the FSM to IDLE.
  - Requesters hold VALID and DATA stable until READY. The controller does not check this.
- Blink logic:
  - The free-running counter counts 0..BLINK_DIV-1. At the wrap, blink phase toggles.
  - Digit n is blanked if blank[n] | (blink[n] & phase).
  - A blanked digit outputs 7'h7F.
- Configuration writes:
  - iCFG_WE latches iCFG_BLANK and iCFG_BLINK. It also clears the blink counter and phase to 0, so blinking digits are visible.
  - Writes are accepted in any state and have no effect on arbitration or hold.
- Decode table, active-low, hex value per nibble: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18 A:08 b:03 C:46 d:21 E:06 F:0E.

## Timing

- Handshake edge k latches the value register. oUPDATE is high in cycle k..k+1.
- oHEXn_D reflects the new value after edge k+1 (outputs are registered), giving one cycle of value-to-segment latency.
- After a transfer, both readies stay low for exactly HOLD_CYC cycles. The earliest next transfer is at edge k+HOLD_CYC+1.
- Blank and blink changes reach the segments one edge after the value/config register updates.
- Blink phase toggles every BLINK_DIV cycles, so the full blink period is 2·BLINK_DIV.
- Simultaneous requests alternate strictly when both are held valid.
- A requester that is alone is granted regardless of the pointer.
- Config write and data transfer in the same cycle: both take effect at the same edge.
- Config write on the same edge as a blink wrap: the clear wins, and phase = 0.
- Reset mid-HOLD aborts the hold immediately. Outputs return to reset values asynchronously.

## Test plan

- Reset release, no requests → all oHEXn_D = 7'h40, readies 0, oOWNER = 0.
- HOLD_CYC=3: REQ0 writes 32'h76543210 → oREQ0_READY high in that cycle, then:
  - oUPDATE pulses for one cycle;
  - after edge k+1, HEX0..HEX7 = 40,79,24,30,19,12,02,78;
  - readies stay 0 for 3 cycles.
- Both VALID held with 0xAAAAAAAA and 0xBBBBBBBB:
  - grants go 0,1,0,1, each separated by HOLD_CYC idle-ready cycles;
  - oOWNER follows the grants;
  - digits alternate between 08 and 03.
- HOLD_CYC=0: REQ1 valid every cycle → ready every cycle, and a new value is latched each edge.
- BLINK_DIV=4, CFG blink=8'h01, blank=8'h80:
  - HEX7 = 7F always;
  - HEX0 alternates between its digit and 7F every 4 cycles, starting visible right after the config write.
- Assert iRST_N low during HOLD → readies 0 and segments 7'h40 without waiting for a clock. After release, REQ0 wins the first tie.

Source files
------------

// File: rtl/seg_hex_display_ctrl_if.sv
// Valid/ready write channels of the two requesters sharing the HEX display.
// The master drives valid/data; the display controller (slave) returns ready.
interface seg_hex_display_ctrl_if;
   logic        req0_valid;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [31:0] req1_data;
   logic        req1_ready;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/seg_hex_display_ctrl.sv
// Eight-digit HEX display controller: two-requester round-robin write port,
// minimum hold time per value, per-digit blank/blink, registered segment decode.
module seg_hex_display_ctrl #(
   parameter int unsigned HOLD_CYC  = 25_000_000,
   parameter int unsigned BLINK_DIV = 12_500_000
) (
   input  logic                   iCLK,
   input  logic                   iRST_N,
   seg_hex_display_ctrl_if.slave  req_bus,
   input  logic                   iCFG_WE,
   input  logic [7:0]             iCFG_BLANK,
   input  logic [7:0]             iCFG_BLINK,
   output logic [6:0]             oHEX0_D,
   output logic [6:0]             oHEX1_D,
   output logic [6:0]             oHEX2_D,
   output logic [6:0]             oHEX3_D,
   output logic [6:0]             oHEX4_D,
   output logic [6:0]             oHEX5_D,
   output logic [6:0]             oHEX6_D,
   output logic [6:0]             oHEX7_D,
   output logic                   oOWNER,
   output logic                   oUPDATE
);

   localparam int unsigned HOLD_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LOAD  = (HOLD_CYC > 0) ? HOLD_W'(HOLD_CYC - 1) : '0;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } state_t;

   state_t               state_q,     state_d;
   logic [HOLD_W-1:0]    hold_cnt_q,  hold_cnt_d;
   logic [31:0]          value_q,     value_d;
   logic [7:0]           blank_q,     blank_d;
   logic [7:0]           blink_q,     blink_d;
   logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic                 phase_q,     phase_d;
   logic                 last_q,      last_d;
   logic                 owner_q,     owner_d;
   logic                 update_q,    update_d;
   logic [6:0]           hex_q [8];
   logic [6:0]           hex_d [8];
   logic                 grant0;
   logic                 grant1;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h18;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // Arbitration and hold FSM; last_q points at the most recent winner.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      value_d    = value_q;
      last_d     = last_q;
      owner_d    = owner_q;
      update_d   = 1'b0;
      grant0     = 1'b0;
      grant1     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            grant0 = req_bus.req0_valid & (~req_bus.req1_valid | last_q);
            grant1 = req_bus.req1_valid & (~req_bus.req0_valid | ~last_q);
            if (grant0 | grant1) begin
               value_d  = grant1 ? req_bus.req1_data : req_bus.req0_data;
               owner_d  = grant1;
               last_d   = grant1;
               update_d = 1'b1;
               if (HOLD_CYC > 0) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = HOLD_LOAD;
               end
            end
         end
         ST_HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Readies must read 0 the instant reset is asserted, not at the next edge.
   assign req_bus.req0_ready = grant0 & iRST_N;
   assign req_bus.req1_ready = grant1 & iRST_N;

   // A config write restarts the blink cycle in its visible half.
   always_comb begin
      blank_d     = blank_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (iCFG_WE) begin
         blank_d     = iCFG_BLANK;
         blink_d     = iCFG_BLINK;
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
   end

   always_comb begin
      for (int d = 0; d < 8; d++) begin
         hex_d[d] = seg_decode(value_q[4*d +: 4]);
         if (blank_q[d] | (blink_q[d] & phase_q)) begin
            hex_d[d] = SEG_BLANK;
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= ST_IDLE;
         hold_cnt_q  <= '0;
         value_q     <= '0;
         blank_q     <= '0;
         blink_q     <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         update_q    <= 1'b0;
         for (int d = 0; d < 8; d++) begin
            hex_q[d] <= SEG_ZERO;
         end
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         value_q     <= value_d;
         blank_q     <= blank_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         update_q    <= update_d;
         for (int d = 0; d < 8; d++) begin
            hex_q[d] <= hex_d[d];
         end
      end
   end

   assign oHEX0_D = hex_q[0];
   assign oHEX1_D = hex_q[1];
   assign oHEX2_D = hex_q[2];
   assign oHEX3_D = hex_q[3];
   assign oHEX4_D = hex_q[4];
   assign oHEX5_D = hex_q[5];
   assign oHEX6_D = hex_q[6];
   assign oHEX7_D = hex_q[7];
   assign oOWNER  = owner_q;
   assign oUPDATE = update_q;

endmodule

// File: tb/tb_seg_hex_display_ctrl.sv
// Two display controllers (HOLD_CYC=3/BLINK_DIV=4 and HOLD_CYC=0/BLINK_DIV=3)
// checked every cycle against a cycle-count based reference model.
module tb_seg_hex_display_ctrl;

   localparam int HOLD_P  [2] = '{3, 0};
   localparam int BLINK_P [2] = '{4, 3};
   localparam logic [55:0] ZERO_HEX = {8{7'h40}};

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0]  v0, v1, we;
   logic [31:0] d0 [2];
   logic [31:0] d1 [2];
   logic [7:0]  cblank [2];
   logic [7:0]  cblink [2];
   logic [1:0]  r0, r1, upd, own;
   logic [7:0][6:0] hx [2];

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // reference model state, one slot per DUT
   int          m_edges [2];
   int          m_xfer  [2];
   int          m_cfg   [2];
   logic [31:0] m_val   [2];
   logic [7:0]  m_blank [2];
   logic [7:0]  m_blink [2];
   bit          m_owner [2];
   bit          m_upd   [2];
   bit          m_last  [2];
   logic [55:0] m_hex   [2];
   bit [1:0]    g0, g1;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   seg_hex_display_ctrl_if bus_a ();
   seg_hex_display_ctrl_if bus_b ();

   assign bus_a.req0_valid = v0[0];
   assign bus_a.req0_data  = d0[0];
   assign bus_a.req1_valid = v1[0];
   assign bus_a.req1_data  = d1[0];
   assign bus_b.req0_valid = v0[1];
   assign bus_b.req0_data  = d0[1];
   assign bus_b.req1_valid = v1[1];
   assign bus_b.req1_data  = d1[1];
   assign r0 = {bus_b.req0_ready, bus_a.req0_ready};
   assign r1 = {bus_b.req1_ready, bus_a.req1_ready};

   seg_hex_display_ctrl #(.HOLD_CYC(3), .BLINK_DIV(4)) dut_a (
      .iCLK(clk), .iRST_N(rst_n), .req_bus(bus_a),
      .iCFG_WE(we[0]), .iCFG_BLANK(cblank[0]), .iCFG_BLINK(cblink[0]),
      .oHEX0_D(hx[0][0]), .oHEX1_D(hx[0][1]), .oHEX2_D(hx[0][2]), .oHEX3_D(hx[0][3]),
      .oHEX4_D(hx[0][4]), .oHEX5_D(hx[0][5]), .oHEX6_D(hx[0][6]), .oHEX7_D(hx[0][7]),
      .oOWNER(own[0]), .oUPDATE(upd[0])
   );

   seg_hex_display_ctrl #(.HOLD_CYC(0), .BLINK_DIV(3)) dut_b (
      .iCLK(clk), .iRST_N(rst_n), .req_bus(bus_b),
      .iCFG_WE(we[1]), .iCFG_BLANK(cblank[1]), .iCFG_BLINK(cblink[1]),
      .oHEX0_D(hx[1][0]), .oHEX1_D(hx[1][1]), .oHEX2_D(hx[1][2]), .oHEX3_D(hx[1][3]),
      .oHEX4_D(hx[1][4]), .oHEX5_D(hx[1][5]), .oHEX6_D(hx[1][6]), .oHEX7_D(hx[1][7]),
      .oOWNER(own[1]), .oUPDATE(upd[1])
   );

   initial forever #5 clk = ~clk;

   function automatic logic [55:0] render(input logic [31:0] val, input logic [7:0] bl,
                                          input logic [7:0] bk, input int ph);
      logic [55:0] r;
      for (int d = 0; d < 8; d++) begin
         if (bl[d] || (bk[d] && ph == 1)) r[d*7 +: 7] = 7'h7F;
         else                             r[d*7 +: 7] = seg_tab[val[d*4 +: 4]];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input int inst, input logic [55:0] obs,
                      input logic [55:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_edges[i] = 0;
         m_xfer[i]  = -1000000;
         m_cfg[i]   = 0;
         m_val[i]   = '0;
         m_blank[i] = '0;
         m_blink[i] = '0;
         m_owner[i] = 1'b0;
         m_upd[i]   = 1'b0;
         m_last[i]  = 1'b1;
         m_hex[i]   = ZERO_HEX;
      end
   endtask

   task automatic clr_inputs();
      v0 = '0; v1 = '0; we = '0;
      for (int i = 0; i < 2; i++) begin
         d0[i] = '0; d1[i] = '0; cblank[i] = '0; cblink[i] = '0;
      end
   endtask

   // One clock: check outputs at the falling edge, advance the model at the rising edge.
   task automatic step();
      bit idle;
      int ph;
      logic [55:0] rend;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         idle  = (m_edges[i] >= m_xfer[i] + HOLD_P[i]);
         g0[i] = idle && v0[i] && (!v1[i] || m_last[i]);
         g1[i] = idle && v1[i] && (!v0[i] || !m_last[i]);
         chk("ready0", i, 56'(r0[i]), 56'(g0[i]));
         chk("ready1", i, 56'(r1[i]), 56'(g1[i]));
         chk("update", i, 56'(upd[i]), 56'(m_upd[i]));
         chk("owner",  i, 56'(own[i]), 56'(m_owner[i]));
         chk("hex",    i, hx[i], m_hex[i]);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         ph   = ((m_edges[i] - m_cfg[i]) / BLINK_P[i]) % 2;
         rend = render(m_val[i], m_blank[i], m_blink[i], ph);
         m_upd[i] = g0[i] || g1[i];
         if (g0[i] || g1[i]) begin
            m_val[i]   = g1[i] ? d1[i] : d0[i];
            m_owner[i] = g1[i];
            m_last[i]  = g1[i];
            m_xfer[i]  = m_edges[i] + 1;
         end
         if (we[i]) begin
            m_blank[i] = cblank[i];
            m_blink[i] = cblink[i];
            m_cfg[i]   = m_edges[i] + 1;
         end
         m_hex[i]   = rend;
         m_edges[i] = m_edges[i] + 1;
      end
      #1;
   endtask

   task automatic drop_granted();
      for (int i = 0; i < 2; i++) begin
         if (g0[i]) v0[i] = 1'b0;
         if (g1[i]) v1[i] = 1'b0;
         we[i] = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b1;
      clr_inputs();
      #2 rst_n = 1'b0;
      v0 = 2'b11; v1 = 2'b11;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready0", i, 56'(r0[i]), 56'(0));
         chk("rst_ready1", i, 56'(r1[i]), 56'(0));
         chk("rst_hex",    i, hx[i], ZERO_HEX);
         chk("rst_owner",  i, 56'(own[i]), 56'(0));
      end
      clr_inputs();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      repeat (3) step();

      // REQ0 writes 0x76543210 to both units
      v0 = 2'b11; d0[0] = 32'h7654_3210; d0[1] = 32'h7654_3210;
      step();
      drop_granted();
      step();
      for (int i = 0; i < 2; i++) begin
         chk("hex_76543210", i, hx[i],
             {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});
      end
      repeat (5) step();

      // both requesters held valid: strict alternation
      v0 = 2'b11; v1 = 2'b11;
      for (int i = 0; i < 2; i++) begin
         d0[i] = 32'hAAAA_AAAA; d1[i] = 32'hBBBB_BBBB;
      end
      repeat (18) step();
      clr_inputs();
      repeat (4) step();

      // zero-hold unit takes a new REQ1 value on every edge
      v1[1] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         d1[1] = $urandom;
         step();
      end
      clr_inputs();
      step();

      // blink/blank config; unit B also takes a transfer on the same edge
      we = 2'b11;
      cblank[0] = 8'h80; cblink[0] = 8'h01;
      cblank[1] = 8'h00; cblink[1] = 8'hFF;
      v1[1] = 1'b1; d1[1] = 32'hFEDC_BA98;
      step();
      drop_granted();
      repeat (20) step();

      // randomized traffic with occasional config writes
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!v0[i] && $urandom_range(0, 2) == 0) begin
               v0[i] = 1'b1; d0[i] = $urandom;
            end
            if (!v1[i] && $urandom_range(0, 2) == 0) begin
               v1[i] = 1'b1; d1[i] = $urandom;
            end
            we[i]     = ($urandom_range(0, 19) == 0);
            cblank[i] = 8'($urandom & $urandom & $urandom);
            cblink[i] = 8'($urandom);
         end
         step();
         drop_granted();
      end
      clr_inputs();
      step();

      // reset asserted while unit A is holding
      v0[0] = 1'b1; d0[0] = 32'h1234_5678;
      step();
      v0 = 2'b11; v1 = 2'b11;
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("midrst_ready0", i, 56'(r0[i]), 56'(0));
         chk("midrst_ready1", i, 56'(r1[i]), 56'(0));
         chk("midrst_hex",    i, hx[i], ZERO_HEX);
         chk("midrst_owner",  i, 56'(own[i]), 56'(0));
         chk("midrst_update", i, 56'(upd[i]), 56'(0));
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      step();
      drop_granted();
      clr_inputs();
      repeat (6) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
